// File: rtl/fft_frame_sequencer.sv
// Frames decimated audio samples into the streaming FFT sink port and
// reports the peak bin from the peak detector once per frame.
module fft_frame_sequencer #(
    parameter int N_LOG2  = 12,
    parameter int DATA_W  = 16,
    parameter int DECIM   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clear_err,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sink_ready,
    output logic              sink_valid,
    output logic              sink_sop,
    output logic              sink_eop,
    output logic [DATA_W-1:0] sink_real,
    output logic [DATA_W-1:0] sink_imag,
    input  logic              peak_done,
    input  logic [12:0]       peak_bin,
    output logic              result_valid,
    output logic [12:0]       result_bin,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);

    localparam int LCW = N_LOG2 + 1;
    localparam int DW  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [LCW-1:0] N_VAL    = LCW'(1) << N_LOG2;
    localparam logic [LCW-1:0] N_LAST   = N_VAL - LCW'(1);
    localparam logic [DW-1:0]  DEC_LAST = DW'(DECIM - 1);
    localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        WAIT_PEAK = 2'd2
    } state_t;

    state_t            state_q;
    logic [LCW-1:0]    load_cnt_q;
    logic [DW-1:0]     dec_cnt_q;
    logic [TW-1:0]     timer_q;
    logic              sink_valid_q;
    logic              sink_sop_q;
    logic              sink_eop_q;
    logic [DATA_W-1:0] sink_real_q;
    logic              result_valid_q;
    logic [12:0]       result_bin_q;
    logic              overrun_q;
    logic              timeout_q;

    logic xfer;
    logic accept;

    // Handshake and decimation qualifiers for the current FILL cycle.
    always_comb begin
        xfer   = sink_valid_q && sink_ready;
        accept = sample_valid && (dec_cnt_q == '0) && (load_cnt_q < N_VAL);
    end

    // Frame sequencer: state, holding register, result and sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            load_cnt_q     <= '0;
            dec_cnt_q      <= '0;
            timer_q        <= '0;
            sink_valid_q   <= 1'b0;
            sink_sop_q     <= 1'b0;
            sink_eop_q     <= 1'b0;
            sink_real_q    <= '0;
            result_valid_q <= 1'b0;
            result_bin_q   <= '0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            if (clear_err) begin
                overrun_q <= 1'b0;
                timeout_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q      <= FILL;
                        load_cnt_q   <= '0;
                        dec_cnt_q    <= '0;
                        sink_valid_q <= 1'b0;
                    end
                end
                FILL: begin
                    if (sample_valid) begin
                        dec_cnt_q <= (dec_cnt_q == DEC_LAST) ?
                                     '0 : dec_cnt_q + DW'(1);
                    end
                    if (accept && (!sink_valid_q || xfer)) begin
                        sink_valid_q <= 1'b1;
                        sink_real_q  <= sample_data;
                        sink_sop_q   <= (load_cnt_q == '0);
                        sink_eop_q   <= (load_cnt_q == N_LAST);
                        load_cnt_q   <= load_cnt_q + LCW'(1);
                    end else begin
                        if (accept) begin
                            overrun_q <= 1'b1;
                        end
                        if (xfer) begin
                            sink_valid_q <= 1'b0;
                        end
                    end
                    if (xfer && sink_eop_q) begin
                        state_q <= WAIT_PEAK;
                        timer_q <= '0;
                    end
                end
                WAIT_PEAK: begin
                    if (peak_done) begin
                        result_bin_q   <= peak_bin;
                        result_valid_q <= 1'b1;
                        state_q        <= IDLE;
                    end else if (timer_q == TO_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sink_valid   = sink_valid_q;
    assign sink_sop     = sink_sop_q;
    assign sink_eop     = sink_eop_q;
    assign sink_real    = sink_real_q;
    assign sink_imag    = '0;
    assign result_valid = result_valid_q;
    assign result_bin   = result_bin_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer with N=8, DECIM=2, TIMEOUT=20.
// Expected beats/results are queued by stimulus, checked by a monitor.
module tb_fft_frame_sequencer;

    localparam int N_LOG2  = 3;
    localparam int DATA_W  = 16;
    localparam int DECIM   = 2;
    localparam int TIMEOUT = 20;

    logic              clk;
    logic              reset_n;
    logic              enable;
    logic              clear_err;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              sink_ready;
    logic              sink_valid;
    logic              sink_sop;
    logic              sink_eop;
    logic [DATA_W-1:0] sink_real;
    logic [DATA_W-1:0] sink_imag;
    logic              peak_done;
    logic [12:0]       peak_bin;
    logic              result_valid;
    logic [12:0]       result_bin;
    logic              busy;
    logic              overrun;
    logic              timeout_err;

    fft_frame_sequencer #(
        .N_LOG2 (N_LOG2),
        .DATA_W (DATA_W),
        .DECIM  (DECIM),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .clear_err   (clear_err),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .sink_ready  (sink_ready),
        .sink_valid  (sink_valid),
        .sink_sop    (sink_sop),
        .sink_eop    (sink_eop),
        .sink_real   (sink_real),
        .sink_imag   (sink_imag),
        .peak_done   (peak_done),
        .peak_bin    (peak_bin),
        .result_valid(result_valid),
        .result_bin  (result_bin),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [15:0] d;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t       exp_q[$];
    logic [12:0] res_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare on every beat transfer and result pulse.
    initial begin
        beat_t b;
        logic [12:0] r;
        forever begin
            @(negedge clk);
            if (sink_valid && sink_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL beat: unexpected beat data=%0d", sink_real);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat{data,sop,eop}",
                        {14'd0, sink_real, sink_sop, sink_eop},
                        {14'd0, b.d, b.sop, b.eop});
                    chk("sink_imag", 32'(sink_imag), 32'd0);
                end
            end
            if (result_valid) begin
                if (res_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL result: unexpected pulse bin=%0d", result_bin);
                end else begin
                    r = res_q.pop_front();
                    chk("result_bin", 32'(result_bin), 32'(r));
                end
            end
        end
    end

    task automatic push(input int v, input bit sop, input bit eop);
        beat_t b;
        b.d   = 16'(v);
        b.sop = sop;
        b.eop = eop;
        exp_q.push_back(b);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        sample_data  = 16'(v);
        sample_valid = 1'b1;
        cyc();
        sample_valid = 1'b0;
        cyc();
    endtask

    // Strobes samples base+lo..base+hi; even indices become beats i/2.
    task automatic send_std(input int base, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (i % 2 == 0) push(base + i, i == 0, i == 14);
            send(base + i);
        end
    endtask

    task automatic peak(input int bin, input bit expect_res);
        if (expect_res) res_q.push_back(13'(bin));
        peak_bin  = 13'(bin);
        peak_done = 1'b1;
        cyc();
        peak_done = 1'b0;
    endtask

    task automatic wait_busy();
        int i;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        n_cmp++;
        if (i == 50) begin
            n_err++;
            $display("FAIL wait_busy: busy=0 after 50 cycles, want 1");
        end
        cyc();
    endtask

    initial begin
        int n;
        reset_n      = 1'b0;
        enable       = 1'b0;
        clear_err    = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        sink_ready   = 1'b0;
        peak_done    = 1'b0;
        peak_bin     = '0;

        #12;
        chk("rst outputs",
            {16'd0, sink_valid, sink_sop, sink_eop, result_valid, busy,
             overrun, timeout_err, 9'd0},
            32'd0);
        chk("rst sink_real", 32'(sink_real), 32'd0);
        chk("rst result_bin", 32'(result_bin), 32'd0);
        cyc();
        reset_n = 1'b1;
        cyc();

        // Basic frame
        enable     = 1'b1;
        sink_ready = 1'b1;
        @(negedge clk);
        chk("busy before enable seen", 32'(busy), 32'd0);
        @(negedge clk);
        chk("busy after enable", 32'(busy), 32'd1);
        cyc();
        send_std(0, 0, 15);
        cyc();
        cyc();
        peak(5, 1'b1);
        repeat (3) cyc();
        chk("basic overrun", 32'(overrun), 32'd0);
        chk("basic result_bin", 32'(result_bin), 32'd5);

        // Backpressure hold on beat 3, released on a same-cycle reload
        wait_busy();
        send_std(100, 0, 5);
        sink_ready = 1'b0;
        push(106, 1'b0, 1'b0);
        send(106);
        @(negedge clk);
        chk("stall hold a",
            {13'd0, sink_valid, sink_sop, sink_eop, sink_real},
            {13'd0, 1'b1, 1'b0, 1'b0, 16'd106});
        send(107);
        @(negedge clk);
        chk("stall hold b",
            {13'd0, sink_valid, sink_sop, sink_eop, sink_real},
            {13'd0, 1'b1, 1'b0, 1'b0, 16'd106});
        cyc();
        sink_ready = 1'b1;
        push(108, 1'b0, 1'b0);
        send(108);
        send_std(100, 9, 15);
        cyc();
        peak(3, 1'b1);
        repeat (2) cyc();
        chk("stall overrun", 32'(overrun), 32'd0);

        // Overrun: second accepted sample dropped while stalled
        wait_busy();
        send_std(200, 0, 3);
        sink_ready = 1'b0;
        push(204, 1'b0, 1'b0);
        send(204);
        send(205);
        send(206);
        chk("overrun set", 32'(overrun), 32'd1);
        chk("overrun held data", 32'(sink_real), 32'd204);
        sink_ready = 1'b1;
        for (int i = 7; i <= 16; i++) begin
            if (i % 2 == 0) push(200 + i, 1'b0, i == 16);
            send(200 + i);
        end
        cyc();
        cyc();
        peak(7, 1'b1);
        repeat (2) cyc();
        chk("overrun sticky", 32'(overrun), 32'd1);
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
        @(negedge clk);
        chk("overrun cleared", 32'(overrun), 32'd0);

        // Timeout: no peak_done after a full frame
        wait_busy();
        send_std(300, 0, 15);
        n = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                n = i;
                break;
            end
        end
        chk("timeout latency", 32'(n), 32'd18);
        chk("timeout busy idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("timeout refill busy", 32'(busy), 32'd1);

        // enable dropped after beat 4: frame still completes
        cyc();
        send_std(400, 0, 9);
        enable = 1'b0;
        send_std(400, 10, 15);
        cyc();
        peak(9, 1'b1);
        repeat (3) @(negedge clk);
        chk("enable drop idle", 32'(busy), 32'd0);
        chk("timeout sticky", 32'(timeout_err), 32'd1);
        cyc();
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
        @(negedge clk);
        chk("timeout cleared", 32'(timeout_err), 32'd0);

        // Stray peak_done during FILL, then reset mid-frame
        enable = 1'b1;
        wait_busy();
        peak(31, 1'b0);
        send_std(500, 0, 7);
        chk("stray result_bin", 32'(result_bin), 32'd9);
        sink_ready = 1'b0;
        send(508);
        chk("pre-reset valid", 32'(sink_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid-frame reset flags",
            {16'd0, sink_valid, sink_sop, sink_eop, result_valid, busy,
             overrun, timeout_err, 9'd0},
            32'd0);
        chk("mid-frame reset data", {sink_real, 3'd0, result_bin}, 32'd0);
        enable = 1'b0;
        cyc();
        reset_n    = 1'b1;
        sink_ready = 1'b1;
        repeat (4) cyc();
        chk("beats left", 32'(exp_q.size()), 32'd0);
        chk("results left", 32'(res_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Sequences audio samples into the streaming FFT core one frame at a time and collects the resulting peak bin from the peak detector. Sits between the audio sample source and the FFT sink port. Decimates the incoming samples, frames them with sop/eop, and buffers one beat against FFT backpressure. It then waits for the peak detector's end-of-frame flag and publishes the peak bin to the tuner display logic.

## Interface
Parameters:
- N_LOG2, 12, log2 of FFT frame length N (N = 4096)
- DATA_W, 16, sample width (signed)
- DECIM, 4, keep one of every DECIM input samples (DECIM ≥ 1)
- TIMEOUT, 65535, max cycles to wait for peak_done after the eop beat

Ports (one clock; reset asynchronous, active-low):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  level; run frames continuously while high
- clear_err  in  1  clears sticky error flags
- sample_valid  in  1  one-cycle strobe, new audio sample
- sample_data  in  DATA_W  signed audio sample
- sink_ready  in  1  FFT core can accept a beat
- sink_valid  out  1  beat valid to FFT
- sink_sop  out  1  first beat of frame
- sink_eop  out  1  last beat of frame
- sink_real  out  DATA_W  sample to FFT
- sink_imag  out  DATA_W  constant 0
- peak_done  in  1  peak detector end-of-frame flag (timeEnd)
- peak_bin  in  13  peak detector bin (peak)
- result_valid  out  1  one-cycle pulse, result_bin updated
- result_bin  out  13  last reported peak bin
- busy  out  1  state ≠ IDLE
- overrun  out  1  sticky, sample dropped
- timeout_err  out  1  sticky, peak_done never arrived

## Operation
- States: IDLE, FILL, WAIT_PEAK.
- IDLE:
  - If enable=1, go to FILL next cycle.
  - On entering FILL: clear load_cnt, hold-valid and dec_cnt.
- FILL, decimation:
  - dec_cnt (0..DECIM-1) advances on each sample_valid and wraps.
  - A sample is accepted when sample_valid=1, dec_cnt=0 and load_cnt<N.
- FILL, holding register:
  - An accepted sample loads a one-beat register: sink_valid=1, sink_real=sample_data, sink_sop=(load_cnt==0), sink_eop=(load_cnt==N-1). load_cnt then increments.
  - A beat transfers when sink_valid && sink_ready, which clears sink_valid unless reloaded the same cycle.
  - Accepted sample while the register is full and not transferring: drop it, set overrun, leave load_cnt unchanged.
  - Accepted sample in the same cycle as a transfer: reload, no overrun.
  - Once load_cnt==N, further samples are ignored (not overrun).
- FILL exit: after the eop beat transfers, go to WAIT_PEAK and clear the timer.
- enable deasserted mid-FILL: the frame still completes. Partial frames are never sent.
- WAIT_PEAK:
  - On peak_done=1: result_bin←peak_bin, result_valid pulses, go to IDLE.
  - Otherwise the timer increments. When timer==TIMEOUT-1 and peak_done=0: set timeout_err, go to IDLE, no result.
- peak_done outside WAIT_PEAK is ignored.
- Sticky flags: clear_err clears both; a set event in the same cycle wins.
- sink_imag is always 0. load_cnt is N_LOG2+1 bits wide. The timer is wide enough for TIMEOUT.

## Timing
- Reset values: state IDLE. sink_valid, sink_sop, sink_eop, sink_real, sink_imag, result_valid, result_bin, busy, overrun and timeout_err are all 0.
- Reset mid-frame aborts immediately, with no eop emitted.
- enable seen high in IDLE at cycle t: busy=1 from t+1.
- sample_valid accepted at cycle t: sink_valid=1 at t+1.
- peak_done sampled at cycle t in WAIT_PEAK: result_valid=1 and result_bin updated at t+1. State is IDLE at t+1. A new FILL starts at t+2 if enable=1.
- sink_sop and sink_eop are only meaningful while sink_valid=1. They are held stable with sink_real until the beat transfers.
- sink_valid never drops without a transfer.

## Test plan
Bench parameters: N_LOG2=3 (N=8), DECIM=2, TIMEOUT=20.
- Basic frame:
  - Stimulus: enable=1, sink_ready=1, 16 sample_valid strobes of values 0..15, then peak_done with peak_bin=5.
  - Required: 8 beats of values 0,2,..,14; sop on 0, eop on 14; result_bin=5 with a one-cycle result_valid; overrun=0.
- Backpressure hold:
  - Stimulus: sink_ready=0 for 3 cycles on beat 3, no new accepted sample meanwhile.
  - Required: sink_real/sop/eop stable while stalled; beat transfers once ready=1; no overrun.
- Overrun:
  - Stimulus: sink_ready=0 while two accepted samples arrive.
  - Required: second sample dropped; overrun=1 until clear_err; frame still totals 8 beats with correct sop/eop.
- Timeout:
  - Stimulus: complete frame, no peak_done for 20 cycles.
  - Required: timeout_err=1, result_valid never pulses; next FILL starts while enable=1.
- enable drop and reset:
  - Stimulus: deassert enable after beat 4.
  - Required: frame completes through eop, then IDLE and busy=0.
  - Stimulus: assert reset_n=0 mid-FILL.
  - Required: all outputs 0 immediately.
- Stray peak_done:
  - Stimulus: pulse peak_done during FILL.
  - Required: ignored; result_bin unchanged.
